loop_filter_pi: RTL and testbench

LOOP_FILTER_PI -- requirements
Module: loop_filter_pi

---
 rtl/adpll_pkg.sv | 15 +
 rtl/lock_detect.sv | 100 ++++++++++
 rtl/loop_filter_pi.sv | 158 +++++++++++++++
 tb/tb_loop_filter_pi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and widths for the ADPLL loop filter and its lock detector.
package adpll_pkg;

    localparam int unsigned ERR_W     = 5;
    localparam int unsigned CTRL_W    = 5;
    localparam int unsigned CTRL_LIM  = 31;
    localparam int unsigned ACC_W_DEF = 12;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/lock_detect.sv
// Lock detector: declares lock after LOCK_CNT consecutive in-window errors,
// drops it after MISS_CNT consecutive out-of-window errors while locked.
module lock_detect
    import adpll_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned MISS_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] err_mag,
    input  logic [ERR_W-1:0] lock_win,
    output logic             locked
);

    localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(MISS_CNT + 1);

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;

    logic              in_win_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [MISS_W-1:0] miss_inc_c;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            cnt_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
        end
    end

    // Next-state logic; only an accepted error sample can move the FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_d     = miss_q;
        in_win_c   = (err_mag <= lock_win);
        cnt_inc_c  = cnt_q + CNT_W'(1);
        miss_inc_c = miss_q + MISS_W'(1);

        case (state_q)
            UNLOCKED: begin
                if (err_valid && in_win_c) begin
                    cnt_d   = CNT_W'(1);
                    miss_d  = '0;
                    state_d = (CNT_W'(1) >= CNT_W'(LOCK_CNT)) ? LOCKED : ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (err_valid) begin
                    if (in_win_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c >= CNT_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = UNLOCKED;
                        cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                if (err_valid) begin
                    if (in_win_c) begin
                        miss_d = '0;
                    end else if (miss_inc_c >= MISS_W'(MISS_CNT)) begin
                        state_d = UNLOCKED;
                        miss_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        miss_d = miss_inc_c;
                    end
                end
            end
            default: begin
                state_d = UNLOCKED;
                cnt_d   = '0;
                miss_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    assign locked = locked_q;

endmodule

// File: rtl/loop_filter_pi.sv
// Two-stage PI loop filter for the ADPLL: saturating integrator, shift gains,
// clamped sign-magnitude control output.
// Optional lock detector compiled in with LOOP_FILTER_LOCK_DETECT_EN.
module loop_filter_pi
    import adpll_pkg::*;
#(
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned MISS_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              err_valid,
    input  logic              err_sign,
    input  logic [ERR_W-1:0]  err_mag,
    input  logic [1:0]        kp_sh,
    input  logic [2:0]        ki_sh,
    input  logic              int_clr,
    input  logic [ERR_W-1:0]  lock_win,
    output logic              ctrl_sign,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ctrl_valid,
    output logic              locked
);

    localparam int unsigned E_W   = ERR_W + 1;
    localparam int unsigned SUM_W = ACC_W + 2;

    localparam logic [ACC_W-1:0]        ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]        ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] LIM_P   = SUM_W'(CTRL_LIM);
    localparam logic signed [SUM_W-1:0] LIM_N   = -LIM_P;

    // Stage 1 registers
    logic signed [ACC_W-1:0] integ_q, integ_d;
    logic signed [E_W-1:0]   e_q, e_d;
    logic [1:0]              kp_q, kp_d;
    logic [2:0]              ki_q, ki_d;
    logic                    v1_q, v1_d;

    // Stage 2 (output) registers
    logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic                    ctrl_sign_q, ctrl_sign_d;
    logic                    ctrl_valid_q, ctrl_valid_d;

    logic signed [E_W-1:0]   mag_s_c, e_c;
    logic signed [ACC_W:0]   acc_ext_c, e_acc_c, acc_sum_c;
    logic signed [ACC_W-1:0] integ_sat_c;
    logic signed [SUM_W-1:0] p_ext_c, p_c, i_ext_c, i_c, sum_c, neg_c;

    // Pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ_q      <= '0;
            e_q          <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            v1_q         <= 1'b0;
            ctrl_q       <= '0;
            ctrl_sign_q  <= 1'b0;
            ctrl_valid_q <= 1'b0;
        end else begin
            integ_q      <= integ_d;
            e_q          <= e_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            v1_q         <= v1_d;
            ctrl_q       <= ctrl_d;
            ctrl_sign_q  <= ctrl_sign_d;
            ctrl_valid_q <= ctrl_valid_d;
        end
    end

    // Signed error and saturating integrator update.
    always_comb begin
        mag_s_c   = signed'({1'b0, err_mag});
        e_c       = err_sign ? -mag_s_c : mag_s_c;
        acc_ext_c = {integ_q[ACC_W-1], integ_q};
        e_acc_c   = {{(ACC_W+1-E_W){e_c[E_W-1]}}, e_c};
        acc_sum_c = acc_ext_c + e_acc_c;
        if (acc_sum_c[ACC_W] != acc_sum_c[ACC_W-1]) begin
            integ_sat_c = acc_sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            integ_sat_c = acc_sum_c[ACC_W-1:0];
        end
    end

    // Stage 1: clear beats a coincident sample, which is then dropped.
    always_comb begin
        integ_d = integ_q;
        e_d     = e_q;
        kp_d    = kp_q;
        ki_d    = ki_q;
        v1_d    = 1'b0;
        if (int_clr) begin
            integ_d = '0;
        end else if (err_valid) begin
            integ_d = integ_sat_c;
            e_d     = e_c;
            kp_d    = kp_sh;
            ki_d    = ki_sh;
            v1_d    = 1'b1;
        end
    end

    // Stage 2: proportional + integral sum, clamp, sign-magnitude conversion.
    always_comb begin
        p_ext_c      = {{(SUM_W-E_W){e_q[E_W-1]}}, e_q};
        p_c          = p_ext_c <<< kp_q;
        i_ext_c      = {{2{integ_q[ACC_W-1]}}, integ_q};
        i_c          = i_ext_c >>> ki_q;
        sum_c        = p_c + i_c;
        neg_c        = -sum_c;
        ctrl_d       = ctrl_q;
        ctrl_sign_d  = ctrl_sign_q;
        ctrl_valid_d = 1'b0;
        if (v1_q) begin
            ctrl_valid_d = 1'b1;
            if (sum_c > LIM_P) begin
                ctrl_d      = CTRL_W'(CTRL_LIM);
                ctrl_sign_d = 1'b1;
            end else if (sum_c < LIM_N) begin
                ctrl_d      = CTRL_W'(CTRL_LIM);
                ctrl_sign_d = 1'b0;
            end else if (sum_c[SUM_W-1]) begin
                ctrl_d      = CTRL_W'(neg_c);
                ctrl_sign_d = 1'b0;
            end else begin
                ctrl_d      = CTRL_W'(sum_c);
                ctrl_sign_d = (sum_c != '0);
            end
        end
    end

    assign ctrl       = ctrl_q;
    assign ctrl_sign  = ctrl_sign_q;
    assign ctrl_valid = ctrl_valid_q;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
    // Lock detector watches the raw error magnitude, independent of int_clr.
    lock_detect #(
        .LOCK_CNT (LOCK_CNT),
        .MISS_CNT (MISS_CNT)
    ) u_lock_detect (
        .clk       (clk),
        .reset     (reset),
        .err_valid (err_valid),
        .err_mag   (err_mag),
        .lock_win  (lock_win),
        .locked    (locked)
    );
`else
    logic unused_c;
    assign unused_c = ^{lock_win, LOCK_CNT[0], MISS_CNT[0]};
    assign locked   = 1'b0;
`endif

endmodule

// File: tb/tb_loop_filter_pi.sv
// Directed self-checking bench for loop_filter_pi.
module tb_loop_filter_pi;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       err_valid;
    logic       err_sign;
    logic [4:0] err_mag;
    logic [1:0] kp_sh;
    logic [2:0] ki_sh;
    logic       int_clr;
    logic [4:0] lock_win;
    logic       ctrl_sign;
    logic [4:0] ctrl;
    logic       ctrl_valid;
    logic       locked;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    logic ok;

    loop_filter_pi dut (
        .clk        (clk),
        .reset      (reset),
        .err_valid  (err_valid),
        .err_sign   (err_sign),
        .err_mag    (err_mag),
        .kp_sh      (kp_sh),
        .ki_sh      (ki_sh),
        .int_clr    (int_clr),
        .lock_win   (lock_win),
        .ctrl_sign  (ctrl_sign),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic s, input logic [4:0] m);
        check({tag, "_valid"}, 32'(ctrl_valid), 32'(v));
        check({tag, "_sign"},  32'(ctrl_sign),  32'(s));
        check({tag, "_ctrl"},  32'(ctrl),       32'(m));
    endtask

    // One clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ctrl_valid === 1'b1) vcnt++;
    endtask

    // Present one error sample for a single cycle.
    task automatic sample(input logic s, input logic [4:0] m, input logic [1:0] kp,
                          input logic [2:0] ki, input logic clr);
        err_valid = 1'b1;
        err_sign  = s;
        err_mag   = m;
        kp_sh     = kp;
        ki_sh     = ki;
        int_clr   = clr;
        tick();
        err_valid = 1'b0;
        int_clr   = 1'b0;
    endtask

    task automatic clear_integ();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        err_valid = 1'b0;
        err_sign  = 1'b0;
        err_mag   = 5'd0;
        kp_sh     = 2'd0;
        ki_sh     = 3'd0;
        int_clr   = 1'b0;
        lock_win  = 5'd2;
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 5'd0);
        check("reset_locked", 32'(locked), 32'd0);
        reset = 1'b0;
        tick();

        // +3, kp=1, ki=0 -> 6+3 = 9 at N+2, held afterwards
        sample(1'b0, 5'd3, 2'd1, 3'd0, 1'b0);
        check("basic_n1_valid", 32'(ctrl_valid), 32'd0);
        tick();
        check_out("basic_n2", 1'b1, 1'b1, 5'd9);
        tick();
        check_out("basic_hold", 1'b0, 1'b1, 5'd9);

        // negative error: integ=-5, sum=-10
        clear_integ();
        sample(1'b1, 5'd5, 2'd0, 3'd0, 1'b0);
        tick();
        check_out("neg", 1'b1, 1'b0, 5'd10);

        // positive saturation: 70 x +31, kp=3 -> clamp 31, integ pinned at 2047
        clear_integ();
        vcnt = 0;
        ok   = 1'b1;
        for (int i = 0; i < 70; i++) begin
            sample(1'b0, 5'd31, 2'd3, 3'd0, 1'b0);
            if (ctrl_valid === 1'b1 && !(ctrl === 5'd31 && ctrl_sign === 1'b1)) ok = 1'b0;
        end
        tick();
        if (ctrl_valid === 1'b1 && !(ctrl === 5'd31 && ctrl_sign === 1'b1)) ok = 1'b0;
        tick();
        check("sat_pos_clamp", 32'(ok), 32'd1);
        check("sat_pos_count", 32'(vcnt), 32'd70);
        sample(1'b0, 5'd0, 2'd0, 3'd7, 1'b0);
        tick();
        check_out("sat_pos_integ", 1'b1, 1'b1, 5'd15);      // 2047>>>7 = 15
        sample(1'b1, 5'd31, 2'd0, 3'd7, 1'b0);
        tick();
        check_out("sat_pos_back", 1'b1, 1'b0, 5'd16);       // -31 + (2016>>>7)

        // negative saturation: integ pinned at -2048
        clear_integ();
        ok = 1'b1;
        for (int i = 0; i < 70; i++) begin
            sample(1'b1, 5'd31, 2'd0, 3'd0, 1'b0);
            if (ctrl_valid === 1'b1 && !(ctrl === 5'd31 && ctrl_sign === 1'b0)) ok = 1'b0;
        end
        tick();
        tick();
        check("sat_neg_clamp", 32'(ok), 32'd1);
        sample(1'b0, 5'd0, 2'd0, 3'd7, 1'b0);
        tick();
        check_out("sat_neg_integ", 1'b1, 1'b0, 5'd16);      // -2048>>>7 = -16
        sample(1'b0, 5'd31, 2'd0, 3'd7, 1'b0);
        tick();
        check_out("sat_neg_back", 1'b1, 1'b1, 5'd15);       // 31 + (-2017>>>7)

        // -5, clear+(-5) discarded, then 0 -> two pulses, last one zero
        clear_integ();
        vcnt = 0;
        sample(1'b1, 5'd5, 2'd0, 3'd0, 1'b0);
        sample(1'b1, 5'd5, 2'd0, 3'd0, 1'b1);
        check_out("clr_first", 1'b1, 1'b0, 5'd10);
        sample(1'b0, 5'd0, 2'd0, 3'd0, 1'b0);
        check("clr_dropped_valid", 32'(ctrl_valid), 32'd0);
        tick();
        check_out("clr_last", 1'b1, 1'b0, 5'd0);
        tick();
        tick();
        tick();
        check("clr_pulse_count", 32'(vcnt), 32'd2);

        // negative zero behaves as zero
        sample(1'b1, 5'd0, 2'd0, 3'd0, 1'b0);
        tick();
        check_out("neg_zero", 1'b1, 1'b0, 5'd0);

        // gains sampled with the error; later changes do not affect it
        clear_integ();
        sample(1'b0, 5'd2, 2'd2, 3'd0, 1'b0);
        kp_sh = 2'd0;
        ki_sh = 3'd7;
        tick();
        check_out("gain_inflight", 1'b1, 1'b1, 5'd10);

        // reset the cycle after a sample: nothing emitted, outputs zero
        sample(1'b0, 5'd7, 2'd0, 3'd0, 1'b0);
        reset = 1'b1;
        #1;
        check_out("rst_mid_async", 1'b0, 1'b0, 5'd0);
        check("rst_mid_locked", 32'(locked), 32'd0);
        vcnt = 0;
        tick();
        tick();
        check_out("rst_mid_held", 1'b0, 1'b0, 5'd0);
        reset = 1'b0;
        tick();
        tick();
        check("rst_mid_no_valid", 32'(vcnt), 32'd0);
        sample(1'b0, 5'd3, 2'd0, 3'd0, 1'b0);
        check("rst_first_n1", 32'(ctrl_valid), 32'd0);
        tick();
        check_out("rst_first_n2", 1'b1, 1'b1, 5'd6);

        // nonzero P and I cancelling to zero
        clear_integ();
        sample(1'b0, 5'd4, 2'd0, 3'd0, 1'b0);
        tick();
        check_out("zero_pre", 1'b1, 1'b1, 5'd8);
        sample(1'b1, 5'd2, 2'd0, 3'd0, 1'b0);
        tick();
        check_out("zero_sum", 1'b1, 1'b0, 5'd0);

        // lock acquisition and loss (lock_win = 2)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            sample(1'b0, 5'd1, 2'd0, 3'd0, 1'b0);
            if (i == 14) check("lock_after15", 32'(locked), 32'd0);
        end
        check("lock_after16", 32'(locked), 32'(LOCK_EN));
        for (int i = 0; i < 3; i++) sample(1'b0, 5'd7, 2'd0, 3'd0, 1'b0);
        check("lock_3miss", 32'(locked), 32'(LOCK_EN));
        sample(1'b0, 5'd0, 2'd0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) sample(1'b0, 5'd7, 2'd0, 3'd0, 1'b0);
        check("lock_miss_reset", 32'(locked), 32'(LOCK_EN));
        sample(1'b0, 5'd7, 2'd0, 3'd0, 1'b0);
        check("lock_lost", 32'(locked), 32'd0);

        // 15 in, 1 out (|3| > 2), 15 in (one with int_clr) -> still unlocked
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sample(1'b1, 5'd2, 2'd0, 3'd0, 1'b0);
            if (locked !== 1'b0) ok = 1'b0;
        end
        sample(1'b0, 5'd3, 2'd0, 3'd0, 1'b0);
        if (locked !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            sample(1'b1, 5'd2, 2'd0, 3'd0, (i == 4) ? 1'b1 : 1'b0);
            if (locked !== 1'b0) ok = 1'b0;
        end
        check("nolock_15_1_15", 32'(ok), 32'd1);
        sample(1'b1, 5'd2, 2'd0, 3'd0, 1'b0);
        check("lock_16th_with_clr", 32'(locked), 32'(LOCK_EN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
